// File: rtl/writeback_regfile.sv
// Write-back stage: selects load or ALU data, commits it into a 32-entry register file
// with x0 hardwired to zero, and serves two bypassed read ports plus a forwarding tap.
module writeback_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MEM_WB_regwrite,
    input  logic             MEM_WB_memread,
    input  logic [AW-1:0]    MEM_WB_rd,
    input  logic [XLEN-1:0]  MEM_WB_alures,
    input  logic [XLEN-1:0]  MEM_WB_memres,
    input  logic             wb_stall,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic             wb_fwd_valid,
    output logic [AW-1:0]    wb_fwd_rd,
    output logic [XLEN-1:0]  wb_fwd_data,
    output logic [AW-1:0]    wb_last_rd,
    output logic [XLEN-1:0]  wb_last_data,
    output logic [CNT_W-1:0] wb_count
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [AW-1:0]    r_last_rd;
    logic [XLEN-1:0]  r_last_data;
    logic [CNT_W-1:0] r_count;

    logic [XLEN-1:0]  w_wb_data;
    logic             w_commit;

    // Read one port: x0 is always zero; a commit in flight is bypassed to Decode.
    function automatic logic [XLEN-1:0] read_port(
        input logic [AW-1:0]   addr,
        input logic            commit,
        input logic [AW-1:0]   rd,
        input logic [XLEN-1:0] wdata,
        input logic [XLEN-1:0] stored
    );
        logic [XLEN-1:0] result;
        if (addr == {AW{1'b0}}) begin
            result = {XLEN{1'b0}};
        end else if (commit && (addr == rd)) begin
            result = wdata;
        end else begin
            result = stored;
        end
        return result;
    endfunction

    // Write-back data select and commit qualification.
    always_comb begin
        w_wb_data = MEM_WB_alures;
        w_commit  = 1'b0;
        if (MEM_WB_memread) begin
            w_wb_data = MEM_WB_memres;
        end else begin
            w_wb_data = MEM_WB_alures;
        end
        if (MEM_WB_regwrite && !wb_stall && (MEM_WB_rd != {AW{1'b0}})) begin
            w_commit = 1'b1;
        end else begin
            w_commit = 1'b0;
        end
    end

    // Register array; entry 0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= {XLEN{1'b0}};
            end
        end else if (w_commit) begin
            r_regs[MEM_WB_rd] <= w_wb_data;
        end else begin
            r_regs[MEM_WB_rd] <= r_regs[MEM_WB_rd];
        end
    end

    // Last-commit record and committed-write counter (wraps modulo 2^CNT_W).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_rd   <= {AW{1'b0}};
            r_last_data <= {XLEN{1'b0}};
            r_count     <= {CNT_W{1'b0}};
        end else if (w_commit) begin
            r_last_rd   <= MEM_WB_rd;
            r_last_data <= w_wb_data;
            r_count     <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_last_rd   <= r_last_rd;
            r_last_data <= r_last_data;
            r_count     <= r_count;
        end
    end

    // Decode read ports and the forwarding tap.
    always_comb begin
        rs1_data     = read_port(rs1_addr, w_commit, MEM_WB_rd, w_wb_data, r_regs[rs1_addr]);
        rs2_data     = read_port(rs2_addr, w_commit, MEM_WB_rd, w_wb_data, r_regs[rs2_addr]);
        wb_fwd_valid = w_commit;
        wb_fwd_rd    = MEM_WB_rd;
        wb_fwd_data  = w_wb_data;
    end

    assign wb_last_rd   = r_last_rd;
    assign wb_last_data = r_last_data;
    assign wb_count     = r_count;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile with a small reference model of the register file;
// the counter is built 4 bits wide so that wrap-around is reachable quickly.
module tb_writeback_regfile;

    logic        clk;
    logic        rst_n;
    logic        regwrite;
    logic        memread;
    logic [4:0]  rd;
    logic [31:0] alures;
    logic [31:0] memres;
    logic        stall;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic [4:0]  last_rd;
    logic [31:0] last_data;
    logic [3:0]  count;

    int n_checks;
    int n_errors;

    logic [31:0] model [32];
    logic [4:0]  exp_last_rd;
    logic [31:0] exp_last_data;
    logic [3:0]  exp_count;

    writeback_regfile #(.XLEN(32), .NREGS(32), .CNT_W(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .MEM_WB_regwrite (regwrite),
        .MEM_WB_memread  (memread),
        .MEM_WB_rd       (rd),
        .MEM_WB_alures   (alures),
        .MEM_WB_memres   (memres),
        .wb_stall        (stall),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .wb_fwd_valid    (fwd_valid),
        .wb_fwd_rd       (fwd_rd),
        .wb_fwd_data     (fwd_data),
        .wb_last_rd      (last_rd),
        .wb_last_data    (last_data),
        .wb_count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic mr, input logic [4:0] d,
                         input logic [31:0] a, input logic [31:0] m, input logic st);
        regwrite = rw;
        memread  = mr;
        rd       = d;
        alures   = a;
        memres   = m;
        stall    = st;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 32'h0000_0000, 32'h0000_0000, 1'b0);
    endtask

    // Advance one clock, updating the model with whatever commit the inputs describe.
    task automatic clock_edge();
        logic        cm;
        logic [31:0] wd;
        cm = regwrite && !stall && (rd != 5'd0);
        wd = memread ? memres : alures;
        @(posedge clk);
        if (cm && rst_n) begin
            model[rd]     = wd;
            exp_last_rd   = rd;
            exp_last_data = wd;
            exp_count     = exp_count + 4'd1;
        end
        #1;
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_count"}, {28'd0, count}, {28'd0, exp_count});
        check_eq({tag, "_last_rd"}, {27'd0, last_rd}, {27'd0, exp_last_rd});
        check_eq({tag, "_last_data"}, last_data, exp_last_data);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 32'h0000_0000;
        exp_last_rd   = 5'd0;
        exp_last_data = 32'h0000_0000;
        exp_count     = 4'd0;
    endtask

    initial begin
        logic        cm;
        logic [31:0] wd;
        logic [31:0] exp_rs;
        n_checks = 0;
        n_errors = 0;
        model_reset();
        rst_n    = 1'b0;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        rs1_addr = 5'd5;
        #1;
        check_state("reset");
        check_eq("reset_rs1", rs1_data, 32'h0000_0000);

        // ALU commit
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
        clock_edge();
        idle();
        rs1_addr = 5'd5;
        #1;
        check_eq("alu_rs1", rs1_data, 32'hDEAD_BEEF);
        check_eq("alu_count", {28'd0, count}, 32'd1);
        check_eq("alu_last_rd", {27'd0, last_rd}, 32'd5);

        // Load commit selects memres over alures
        drive(1'b1, 1'b1, 5'd7, 32'h1234_5678, 32'h0000_0100, 1'b0);
        #1;
        check_eq("load_fwd_data", fwd_data, 32'h0000_0100);
        clock_edge();
        idle();
        rs2_addr = 5'd7;
        #1;
        check_eq("load_rs2", rs2_data, 32'h0000_0100);
        check_state("load");

        // Same-cycle bypass on both ports
        drive(1'b1, 1'b0, 5'd9, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0);
        rs1_addr = 5'd9;
        rs2_addr = 5'd9;
        #1;
        check_eq("byp_rs1", rs1_data, 32'hA5A5_A5A5);
        check_eq("byp_rs2", rs2_data, 32'hA5A5_A5A5);
        check_eq("byp_fwd_valid", {31'd0, fwd_valid}, 32'd1);
        check_eq("byp_fwd_rd", {27'd0, fwd_rd}, 32'd9);
        clock_edge();
        idle();
        #1;
        check_eq("byp_array_rs1", rs1_data, 32'hA5A5_A5A5);

        // rd=0 write is a NOP
        drive(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        rs1_addr = 5'd0;
        #1;
        check_eq("x0_rs1", rs1_data, 32'h0000_0000);
        check_eq("x0_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        clock_edge();
        idle();
        #1;
        check_state("x0");
        check_eq("x0_after", rs1_data, 32'h0000_0000);

        // Stall suppresses write, bypass and forwarding
        drive(1'b1, 1'b0, 5'd3, 32'h1111_1111, 32'h0000_0000, 1'b1);
        rs1_addr = 5'd3;
        #1;
        check_eq("stall_rs1", rs1_data, 32'h0000_0000);
        check_eq("stall_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        clock_edge();
        idle();
        #1;
        check_eq("stall_x3", rs1_data, 32'h0000_0000);
        check_state("stall");

        // 16 commits cycling over x1..x15: counter comes back to its start value
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 5'((i % 15) + 1), 32'hC000_0000 + 32'(i), 32'h0000_0000, 1'b0);
            clock_edge();
            check_eq("wrap_count", {28'd0, count}, {28'd0, exp_count});
        end
        check_eq("wrap_full_cycle", {28'd0, count}, 32'd3);
        idle();

        // Pseudo-random traffic against the reference model
        for (int i = 0; i < 10; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  $urandom, $urandom, 1'($urandom_range(0, 4) == 0));
            rs1_addr = 5'($urandom_range(0, 31));
            rs2_addr = rd;
            #1;
            cm = regwrite && !stall && (rd != 5'd0);
            wd = memread ? memres : alures;
            exp_rs = (rs1_addr == 5'd0) ? 32'h0 : ((cm && rs1_addr == rd) ? wd : model[rs1_addr]);
            check_eq("rand_rs1", rs1_data, exp_rs);
            exp_rs = (rs2_addr == 5'd0) ? 32'h0 : (cm ? wd : model[rs2_addr]);
            check_eq("rand_rs2", rs2_data, exp_rs);
            check_eq("rand_fwd_valid", {31'd0, fwd_valid}, {31'd0, cm});
            clock_edge();
            check_state("rand");
        end
        idle();
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            #1;
            check_eq("sweep", rs1_data, model[i]);
        end

        // Mid-run reset clears everything immediately
        rs1_addr = 5'd5;
        rs2_addr = 5'd9;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_rs1", rs1_data, 32'h0000_0000);
        check_eq("rst_rs2", rs2_data, 32'h0000_0000);
        check_state("rst");

        // Commit presented while reset is held across the edge is dropped
        drive(1'b1, 1'b0, 5'd4, 32'h4444_4444, 32'h0000_0000, 1'b0);
        clock_edge();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        rs1_addr = 5'd4;
        #1;
        check_eq("rst_drop_x4", rs1_data, 32'h0000_0000);
        check_state("rst_drop");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
